dct_tpose_ctrl: RTL

//  Sequencer for a ping-pong pair of 8x8 DCT transpose line buffers (bank0/bank1).
//  - Accepts row vectors from the row-DCT stage and issues write strobes to the bank being filled.
//  - Issues read strobes to the opposite bank, which returns column vectors to the column-DCT stage.
//  - Writes and reads overlap, so the steady-state rate is one row in and one column out per cycle.
//  - Owns all bank selection, row/column counting, back-pressure and block bookkeeping.

---
 rtl/dct_pkg.sv | 25 ++
 rtl/dct_blk_counter.sv | 48 ++++
 rtl/dct_tpose_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT transpose buffer controller.
//  - DCT_N      : rows per block = columns per block (power of two)
//  - DCT_CNT_W  : width of row/column counters, log2(DCT_N)
//  - DCT_PIX_W  : pixel width used by the surrounding datapath
//  - bank_t     : index of one of the two ping-pong banks
//  - bank_onehot: converts a bank index into a per-bank strobe vector
package dct_pkg;

  localparam int DCT_N     = 8;
  localparam int DCT_CNT_W = 3;
  localparam int DCT_PIX_W = 12;

  typedef logic bank_t;

  function automatic logic [1:0] bank_onehot(input bank_t bank);
    logic [1:0] strobe;
    case (bank)
      1'b0:    strobe = 2'b01;
      1'b1:    strobe = 2'b10;
      default: strobe = 2'b00;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/dct_blk_counter.sv
// Wrap counter with terminal-count flag, used for the row (write) and
// column (read) positions inside a block.
//  i_clk  : clock
//  i_rst  : synchronous reset, active-high
//  i_clr  : synchronous clear (flush), same effect as reset
//  i_inc  : advance by one; wraps to 0 after MAX
//  o_cnt  : current count
//  o_tc   : count equals MAX (an increment now wraps)
module dct_blk_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign o_tc  = (cnt_q == W'(MAX));
  assign o_cnt = cnt_q;

  // Next count: clear wins, otherwise increment with wrap at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = {W{1'b0}};
    end else if (i_inc) begin
      cnt_d = o_tc ? {W{1'b0}} : cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dct_tpose_ctrl.sv
// Sequencer for a ping-pong pair of 8x8 DCT transpose line buffers.
// Rows from the row-DCT stage are written into the bank being filled while
// columns are read from the opposite (full) bank, one of each per cycle.
//  i_clk, i_rst     : clock, synchronous active-high reset
//  i_flush          : abort in-flight blocks (reset state, block count kept)
//  i_row_valid      : upstream row valid     / o_row_ready : row accepted
//  o_wr, o_wr_row   : per-bank write strobe and row index
//  o_rd, o_rd_sel   : per-bank read strobe and column-mux select
//  o_col_valid      : column valid           / i_col_ready : column accepted
//  o_col_idx        : column index presented / o_last_col  : it is column N-1
//  o_blk_done       : registered pulse after the last column of a block
//  o_blk_cnt        : completed blocks, wraps
//  o_buf_rst_n      : active-low buffer pointer reset (combinational)
module dct_tpose_ctrl
  import dct_pkg::*;
#(
  parameter int N     = DCT_N,
  parameter int CNT_W = DCT_CNT_W,
  parameter int BLK_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_row_valid,
  output logic             o_row_ready,
  output logic [1:0]       o_wr,
  output logic [CNT_W-1:0] o_wr_row,
  output logic [1:0]       o_rd,
  output logic             o_rd_sel,
  output logic             o_col_valid,
  input  logic             i_col_ready,
  output logic [CNT_W-1:0] o_col_idx,
  output logic             o_last_col,
  output logic             o_blk_done,
  output logic [BLK_W-1:0] o_blk_cnt,
  output logic             o_buf_rst_n
);

  logic [1:0]       full_d,     full_q;
  bank_t            wr_bank_d,  wr_bank_q;
  bank_t            rd_bank_d,  rd_bank_q;
  logic             blk_done_d, blk_done_q;
  logic [BLK_W-1:0] blk_cnt_d,  blk_cnt_q;

  logic             abort;
  logic             wr_fire, rd_fire;
  logic             wr_tc, rd_tc;
  logic             wr_wrap, rd_wrap;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  // Handshakes; reset or flush drops any transfer presented this cycle.
  always_comb begin
    abort       = i_rst | i_flush;
    o_row_ready = ~full_q[wr_bank_q];
    o_col_valid = full_q[rd_bank_q];
    wr_fire     = i_row_valid & o_row_ready & ~abort;
    rd_fire     = o_col_valid & i_col_ready & ~abort;
    wr_wrap     = wr_fire & wr_tc;
    rd_wrap     = rd_fire & rd_tc;
    o_wr        = wr_fire ? bank_onehot(wr_bank_q) : 2'b00;
    o_rd        = rd_fire ? bank_onehot(rd_bank_q) : 2'b00;
  end

  dct_blk_counter #(.W(CNT_W), .MAX(N - 1)) u_wr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_flush),
    .i_inc (wr_fire),
    .o_cnt (wr_cnt),
    .o_tc  (wr_tc)
  );

  dct_blk_counter #(.W(CNT_W), .MAX(N - 1)) u_rd_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_flush),
    .i_inc (rd_fire),
    .o_cnt (rd_cnt),
    .o_tc  (rd_tc)
  );

  // Bank bookkeeping. Filling one bank and draining the other can finish in
  // the same cycle; they touch different full bits so both updates apply.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    blk_done_d = 1'b0;
    blk_cnt_d  = blk_cnt_q;
    if (i_flush) begin
      full_d     = 2'b00;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      blk_done_d = 1'b0;
      blk_cnt_d  = blk_cnt_q;
    end else begin
      if (wr_wrap) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
      if (rd_wrap) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
      blk_done_d = rd_wrap;
      blk_cnt_d  = blk_cnt_q + BLK_W'(rd_wrap);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      blk_done_q <= 1'b0;
      blk_cnt_q  <= {BLK_W{1'b0}};
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      blk_done_q <= blk_done_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign o_wr_row    = wr_cnt;
  assign o_col_idx   = rd_cnt;
  assign o_last_col  = rd_tc;
  assign o_rd_sel    = rd_bank_q;
  assign o_blk_done  = blk_done_q;
  assign o_blk_cnt   = blk_cnt_q;
  assign o_buf_rst_n = ~abort;

endmodule
